// File: rtl/seq_alu_unit.sv
// seq_alu_unit
//   Registered, multi-cycle ALU with a start/busy/done handshake. It replaces
//   the combinational datapath ALU and keeps its 3-bit aluControl encoding and
//   its aluSrc immediate select. Operands and opcode are captured when a
//   request is accepted. MUL is an iterative shift-add multiply over a
//   2*WIDTH accumulator. Result and zero/carry/overflow flags are registered
//   and hold their values until the next done pulse.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          operation request, sampled only in IDLE
//   readData1      operand A
//   readData2      operand B when aluSrc = 0
//   sign_extended  operand B when aluSrc = 1
//   aluSrc         B select
//   aluControl     opcode: ADD SUB NEG MUL AND OR XOR NOT (000..111)
//   busy           high while an operation is in flight (EXEC / MUL)
//   done           one-cycle completion pulse
//   result         registered result
//   zero           result == 0
//   carry          ADD carry-out, SUB no-borrow, else 0
//   overflow       signed overflow (ADD/SUB/NEG) or MUL truncation, else 0
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands and opcode latched on accept
// EXEC  | single-cycle op computed; result and flags registered
// MUL   | one multiplier bit per cycle, WIDTH cycles
// DONE  | done pulse for one cycle, busy low; then back to IDLE

module seq_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [WIDTH-1:0] sign_extended,
    input  logic             aluSrc,
    input  logic [2:0]       aluControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NEG = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   neg_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] mul_sum;

    assign b_sel = aluSrc ? sign_extended : readData2;

    // Single-cycle ops, evaluated from the latched operands only.
    always_comb begin
        add_full = {1'b0, a_q} + {1'b0, b_q};
        // Subtract as A + ~B + 1; the carry-out is the "no borrow" flag.
        sub_full = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        neg_res  = ~a_q + WIDTH'(1);
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (add_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (sub_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NEG: begin
                alu_res = neg_res;
                // Only the most negative value has no positive counterpart.
                alu_v   = (a_q == MIN_NEG);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: a_q holds the remaining multiplier bits (LSB first),
    // mcand_q the multiplicand shifted to the current bit weight.
    assign mul_sum = acc_q + (a_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = readData1;
                    b_d     = b_sel;
                    op_d    = aluControl;
                    acc_d   = '0;
                    mcand_d = {{WIDTH{1'b0}}, b_sel};
                    cnt_d   = '0;
                    state_d = (aluControl == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                carry_d  = alu_c;
                ovf_d    = alu_v;
                state_d  = S_DONE;
            end
            S_MUL: begin
                acc_d   = mul_sum;
                a_d     = a_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // No early exit: every multiply takes the full WIDTH steps.
                if (cnt_q == CNT_LAST) begin
                    result_d = mul_sum[WIDTH-1:0];
                    zero_d   = (mul_sum[WIDTH-1:0] == '0);
                    carry_d  = 1'b0;
                    ovf_d    = |mul_sum[2*WIDTH-1:WIDTH];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == S_EXEC) || (state_q == S_MUL);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit
//   Directed bench for seq_alu_unit: one 32-bit and one 8-bit instance on a
//   shared clock and reset. Inputs change on the falling edge, outputs are
//   sampled on the falling edge.

module tb_seq_alu_unit;

    logic        clk;
    logic        rst;

    logic        start32, src32, busy32, done32, zero32, carry32, ovf32;
    logic [31:0] a32, b32, imm32, result32;
    logic [2:0]  op32;

    logic        start8, src8, busy8, done8, zero8, carry8, ovf8;
    logic [7:0]  a8, b8, imm8, result8;
    logic [2:0]  op8;

    int checks = 0;
    int errors = 0;

    seq_alu_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32),
        .readData1(a32), .readData2(b32), .sign_extended(imm32),
        .aluSrc(src32), .aluControl(op32),
        .busy(busy32), .done(done32), .result(result32),
        .zero(zero32), .carry(carry32), .overflow(ovf32)
    );

    seq_alu_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .readData1(a8), .readData2(b8), .sign_extended(imm8),
        .aluSrc(src8), .aluControl(op8),
        .busy(busy8), .done(done8), .result(result8),
        .zero(zero8), .carry(carry8), .overflow(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the selected instance, then check latency, busy during
    // the op, result/flags at done and that done lasts a single cycle.
    task automatic run_op(input string tag, input bit w8,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src,
                          input logic [2:0] op, input logic [31:0] er,
                          input logic ez, input logic ec, input logic ev,
                          input int elat);
        int   lat;
        bit   busy_bad;
        logic dn, bz;
        @(negedge clk);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; imm8 = imm[7:0]; src8 = src; op8 = op; start8 = 1'b1;
        end else begin
            a32 = a; b32 = b; imm32 = imm; src32 = src; op32 = op; start32 = 1'b1;
        end
        @(negedge clk);
        start8   = 1'b0;
        start32  = 1'b0;
        lat      = 1;
        busy_bad = 1'b0;
        forever begin
            dn = w8 ? done8 : done32;
            bz = w8 ? busy8 : busy32;
            if (dn || lat >= 200) break;
            if (!bz) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_busy_gap"}, busy_bad, 1'b0);
        chk({tag, "_result"}, w8 ? {24'b0, result8} : result32, er);
        chk({tag, "_zero"}, w8 ? zero8 : zero32, ez);
        chk({tag, "_carry"}, w8 ? carry8 : carry32, ec);
        chk({tag, "_overflow"}, w8 ? ovf8 : ovf32, ev);
        chk({tag, "_busy_at_done"}, w8 ? busy8 : busy32, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, w8 ? done8 : done32, 1'b0);
    endtask

    initial begin
        int lat;
        bit saw_done;
        bit held_bad;

        rst = 1'b1;
        start32 = 0; a32 = 0; b32 = 0; imm32 = 0; src32 = 0; op32 = 0;
        start8  = 0; a8  = 0; b8  = 0; imm8  = 0; src8  = 0; op8  = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy32, 1'b0);
        chk("rst_done", done32, 1'b0);
        chk("rst_result", result32, 32'h0);
        chk("rst_zero", zero32, 1'b1);
        chk("rst_carry", carry32, 1'b0);
        chk("rst_ovf", ovf32, 1'b0);
        chk("rst_zero8", zero8, 1'b1);
        rst = 1'b0;

        // 32-bit single-cycle ops
        run_op("add_ovf", 0, 32'h7FFFFFFF, 32'h1, 32'h0, 0, 3'b000, 32'h80000000, 0, 0, 1, 2);
        run_op("add_wrap", 0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 3'b000, 32'h0, 1, 1, 0, 2);
        run_op("sub_neg", 0, 32'h5, 32'h3, 32'h7, 1, 3'b001, 32'hFFFFFFFE, 0, 0, 0, 2);
        run_op("sub_eq", 0, 32'h7, 32'h3, 32'h7, 1, 3'b001, 32'h0, 1, 1, 0, 2);
        run_op("neg_min", 0, 32'h80000000, 32'h1234, 32'h0, 0, 3'b010, 32'h80000000, 0, 0, 1, 2);
        run_op("not_zero", 0, 32'h0, 32'h55, 32'h0, 0, 3'b111, 32'hFFFFFFFF, 0, 0, 0, 2);
        run_op("and", 0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0, 0, 3'b100, 32'hF0F00000, 0, 0, 0, 2);
        run_op("or", 0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0, 0, 3'b101, 32'hFFFFF0F0, 0, 0, 0, 2);
        run_op("xor", 0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0, 0, 3'b110, 32'h0F0FF0F0, 0, 0, 0, 2);

        // Reset in the middle of a MUL
        @(negedge clk);
        a32 = 32'h00010000; b32 = 32'h3; src32 = 0; op32 = 3'b011; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("midrst_busy_before", busy32, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy32, 1'b0);
        chk("midrst_done", done32, 1'b0);
        chk("midrst_result", result32, 32'h0);
        chk("midrst_zero", zero32, 1'b1);
        chk("midrst_carry", carry32, 1'b0);
        chk("midrst_ovf", ovf32, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done32) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 1'b0);
        run_op("add_after_rst", 0, 32'h2, 32'h3, 32'h0, 0, 3'b000, 32'h5, 0, 0, 0, 2);

        // 32-bit multiplies
        run_op("mul_trunc", 0, 32'h00010000, 32'h00010000, 32'h0, 0, 3'b011, 32'h0, 1, 0, 1, 33);
        run_op("mul_small", 0, 32'd1234, 32'd5678, 32'h0, 0, 3'b011, 32'd7006652, 0, 0, 0, 33);
        run_op("mul_zero", 0, 32'h0, 32'h5, 32'h0, 0, 3'b011, 32'h0, 1, 0, 0, 33);
        run_op("mul_imm", 0, 32'd6, 32'd1, 32'd7, 1, 3'b011, 32'd42, 0, 0, 0, 33);
        run_op("not_hold", 0, 32'h0, 32'h0, 32'h0, 0, 3'b111, 32'hFFFFFFFF, 0, 0, 0, 2);

        // Handshake: start hammered with new operands during a MUL
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd5; src32 = 0; op32 = 3'b011; start32 = 1'b1;
        @(negedge clk);
        lat = 1;
        held_bad = 1'b0;
        while (!done32 && lat < 200) begin
            a32 = 32'(lat * 7);
            b32 = 32'(lat + 1);
            op32 = lat[2:0];
            src32 = lat[0];
            start32 = 1'b1;
            if (result32 !== 32'hFFFFFFFF) held_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk("hs_latency", lat, 33);
        chk("hs_result_held", held_bad, 1'b0);
        chk("hs_result", result32, 32'd15);
        a32 = 32'd100; b32 = 32'd23; src32 = 0; op32 = 3'b000; start32 = 1'b1;
        @(negedge clk);
        chk("hs_done_start_ignored", busy32, 1'b0);
        chk("hs_idle_done_low", done32, 1'b0);
        @(negedge clk);
        start32 = 1'b0;
        chk("hs_idle_start_accepted", busy32, 1'b1);
        @(negedge clk);
        chk("hs_b2b_done", done32, 1'b1);
        chk("hs_b2b_result", result32, 32'd123);

        // 8-bit instance
        run_op("w8_add_ovf", 1, 32'h7F, 32'h01, 32'h0, 0, 3'b000, 32'h80, 0, 0, 1, 2);
        run_op("w8_add_wrap", 1, 32'hFF, 32'h01, 32'h0, 0, 3'b000, 32'h00, 1, 1, 0, 2);
        run_op("w8_mul_trunc", 1, 32'h10, 32'h10, 32'h0, 0, 3'b011, 32'h00, 1, 0, 1, 9);
        run_op("w8_mul_small", 1, 32'd12, 32'd13, 32'h0, 0, 3'b011, 32'h9C, 0, 0, 0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
